// File: rtl/rx_block_lock_if.sv
// Link between the RX gearbox side and the 64b/66b block-lock engine.
// Handshake: a word is presented when i_valid=1 and i_init_done=1 on a rising
// edge of the word clock. There is no back-pressure. o_slip is a one-cycle
// request to shift the gearbox by one bit. o_block_lock is a level.
// dbg_state reports the lock engine state: 0 = HUNT, 1 = SLIP_WAIT, 2 = LOCKED.
interface rx_block_lock_if;
  logic       i_init_done;
  logic       i_valid;
  logic [1:0] i_header;
  logic       o_slip;
  logic       o_block_lock;
  logic [1:0] dbg_state;

  modport master (
    output i_init_done, i_valid, i_header,
    input  o_slip, o_block_lock, dbg_state
  );

  modport slave (
    input  i_init_done, i_valid, i_header,
    output o_slip, o_block_lock, dbg_state
  );
endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock state machine (IEEE 802.3 Clause 49 style).
// Watches the sync header of each gearbox word, slips the gearbox until the
// header boundary is found, and reports block lock downstream.
module rx_block_lock #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rx_block_lock_if.slave bus
);

  localparam int SW = $clog2(SH_CNT_MAX + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [SW-1:0] SH_LAST  = SW'(SH_CNT_MAX - 1);
  localparam logic [SW-1:0] INV_LAST = SW'(SH_INVALID_MAX - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sh_cnt_q, sh_cnt_d;
  logic [SW-1:0] inv_cnt_q, inv_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          slip_q, slip_d;
  logic          lock_q, lock_d;
  logic          qualified;
  logic          hdr_ok;

  assign qualified = bus.i_valid && bus.i_init_done;
  assign hdr_ok    = (bus.i_header == 2'b01) || (bus.i_header == 2'b10);

  // State, counters and registered outputs; reset and init_done=0 both abort.
  always_ff @(posedge i_clk) begin
    if (i_reset || !bus.i_init_done) begin
      state_q    <= ST_HUNT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  // Next-state: only qualified words advance anything; slip lasts one cycle.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    if (qualified) begin
      case (state_q)
        ST_HUNT: begin
          if (!hdr_ok) begin
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            wait_cnt_d = '0;
            state_d    = ST_SLIP_WAIT;
          end else if (sh_cnt_q == SH_LAST) begin
            lock_d    = 1'b1;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_q + SW'(1);
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_d = '0;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            state_d    = ST_HUNT;
          end else begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
        end
        ST_LOCKED: begin
          // Loss of lock wins over the end-of-window restart.
          if (!hdr_ok && inv_cnt_q == INV_LAST) begin
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = ST_SLIP_WAIT;
          end else if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + SW'(1);
            if (!hdr_ok) begin
              inv_cnt_d = inv_cnt_q + SW'(1);
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign bus.o_slip       = slip_q;
  assign bus.o_block_lock = lock_q;
  assign bus.dbg_state    = state_q;

endmodule
